store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 42 ++++
 rtl/store_buffer.sv | 158 +++++++++++++++
 tb/tb_store_buffer.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: store/load request bundle plus data-memory port.
// slave = store buffer side; master = pipeline and data memory side.
interface store_buffer_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     st_valid;
  logic [ADDRESS_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0]    st_data;
  logic                     st_byte;
  logic                     st_ready;

  logic                     ld_valid;
  logic [ADDRESS_WIDTH-1:0] ld_addr;
  logic                     ld_byte;
  logic [DATA_WIDTH-1:0]    ld_data;
  logic                     ld_stall;

  logic [ADDRESS_WIDTH-1:0] mem_A;
  logic [DATA_WIDTH-1:0]    mem_WD;
  logic                     mem_WE;
  logic                     mem_ADTP;
  logic [DATA_WIDTH-1:0]    mem_RD;

  modport slave (
    input  st_valid, st_addr, st_data, st_byte,
    output st_ready,
    input  ld_valid, ld_addr, ld_byte,
    output ld_data, ld_stall,
    output mem_A, mem_WD, mem_WE, mem_ADTP,
    input  mem_RD
  );

  modport master (
    output st_valid, st_addr, st_data, st_byte,
    input  st_ready,
    output ld_valid, ld_addr, ld_byte,
    input  ld_data, ld_stall,
    input  mem_A, mem_WD, mem_WE, mem_ADTP,
    output mem_RD
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry FIFO of pending stores with load forwarding.
// Ports: clk, rst_n (async, active low), bus (store/load/memory bundle).
module store_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;
  typedef logic [PW-1:0]            ptr_t;
  typedef logic [CW-1:0]            cnt_t;

  addr_t            addr_q [DEPTH];
  addr_t            addr_d [DEPTH];
  data_t            data_q [DEPTH];
  data_t            data_d [DEPTH];
  logic [DEPTH-1:0] byte_q, byte_d;
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  cnt_t             count_q, count_d;

  logic  hit, hit_eq;
  ptr_t  hit_idx, idx;
  logic  full, push, drain, ld_mem;
  logic  stall;
  data_t fwd;

  // Byte ranges [a, a+size-1] wrap modulo 2^ADDRESS_WIDTH; two ranges
  // intersect iff either start lies inside the other range.
  function automatic logic overlap(
    input addr_t a, input logic a_b,
    input addr_t b, input logic b_b
  );
    addr_t a_sz, b_sz;
    a_sz = a_b ? addr_t'(1) : addr_t'(4);
    b_sz = b_b ? addr_t'(1) : addr_t'(4);
    return ((b - a) < a_sz) || ((a - b) < b_sz);
  endfunction

  // Walk oldest to youngest so the last hit is the youngest overlap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + ptr_t'(i);
      if ((cnt_t'(i) < count_q) &&
          overlap(addr_q[idx], byte_q[idx],
                  bus.ld_addr, bus.ld_byte)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
    hit_eq = hit &&
             (addr_q[hit_idx] == bus.ld_addr) &&
             (byte_q[hit_idx] == bus.ld_byte);
  end

  // A clean miss takes the memory port while there is room; a full
  // buffer forces a drain so stores cannot starve behind loads.
  assign full   = (count_q == cnt_t'(DEPTH));
  assign push   = bus.st_valid && !full;
  assign ld_mem = bus.ld_valid && !hit && !full;
  assign drain  = (count_q != '0) && !ld_mem;

  always_comb begin
    stall = 1'b0;
    if (bus.ld_valid) begin
      if (bus.st_valid) begin
        stall = 1'b1;
      end else if (hit) begin
        stall = !hit_eq;
      end else begin
        stall = full;
      end
    end
    bus.ld_stall = rst_n && stall;
    bus.st_ready = rst_n && !full;
  end

  always_comb begin
    bus.mem_A    = '0;
    bus.mem_WD   = '0;
    bus.mem_WE   = 1'b0;
    bus.mem_ADTP = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        ld_mem: begin
          bus.mem_A    = bus.ld_addr;
          bus.mem_ADTP = bus.ld_byte;
        end
        drain: begin
          bus.mem_WE   = 1'b1;
          bus.mem_A    = addr_q[head_q];
          bus.mem_WD   = data_q[head_q];
          bus.mem_ADTP = byte_q[head_q];
        end
        default: ;
      endcase
    end
  end

  // Kept apart from the port logic: mem_RD depends on mem_A.
  always_comb begin
    if (byte_q[hit_idx]) begin
      fwd = {{(DATA_WIDTH-8){1'b0}}, data_q[hit_idx][7:0]};
    end else begin
      fwd = data_q[hit_idx];
    end
    bus.ld_data = '0;
    if (rst_n && bus.ld_valid && !stall) begin
      bus.ld_data = ld_mem ? bus.mem_RD : fwd;
    end
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    byte_d = byte_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) begin
      addr_d[tail_q] = bus.st_addr;
      data_d[tail_q] = bus.st_data;
      byte_d[tail_q] = bus.st_byte;
      tail_d         = tail_q + ptr_t'(1);
    end
    if (drain) begin
      head_d = head_q + ptr_t'(1);
    end
    count_d = count_q + cnt_t'(push) - cnt_t'(drain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
      byte_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      byte_q  <= byte_d;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: vector table, hand sequences and random traffic,
// all checked against a queue-based store buffer reference model.
module tb_store_buffer;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef logic [31:0] w_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  store_buffer #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Data memory seen by the DUT (256-byte window, low address bits).
  logic [7:0] dmem [256] = '{default: 8'h00};
  logic [7:0] refm [256] = '{default: 8'h00};
  w_t wr_addr [$];
  w_t wr_data [$];
  logic [7:0] ia;

  always_comb begin
    ia = bus.mem_A[7:0];
    if (bus.mem_ADTP) begin
      bus.mem_RD = {24'h0, dmem[ia]};
    end else begin
      bus.mem_RD = {dmem[ia + 8'd3], dmem[ia + 8'd2],
                    dmem[ia + 8'd1], dmem[ia]};
    end
  end

  always @(posedge clk) begin
    if (bus.mem_WE) begin
      wr_addr.push_back(bus.mem_A);
      wr_data.push_back(bus.mem_WD);
      if (bus.mem_ADTP) begin
        dmem[bus.mem_A[7:0]] <= bus.mem_WD[7:0];
      end else begin
        for (int k = 0; k < 4; k++)
          dmem[bus.mem_A[7:0] + 8'(k)] <= bus.mem_WD[8*k +: 8];
      end
    end
  end

  // Reference model: pending stores as a plain queue, oldest first.
  typedef struct {
    w_t   addr;
    w_t   data;
    logic b;
  } ent_t;
  ent_t sbq [$];

  logic in_sv, in_sb, in_lv, in_lb;
  w_t   in_sa, in_sd, in_la;

  task automatic chk(input string name, input w_t act, input w_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Overlap by enumerating the actual bytes each access touches.
  function automatic bit ovl(w_t a, logic ab, w_t b, logic bb);
    for (int i = 0; i < (ab ? 1 : 4); i++)
      for (int j = 0; j < (bb ? 1 : 4); j++)
        if (a + w_t'(i) == b + w_t'(j)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic w_t ref_rd(w_t a, logic b);
    logic [7:0] x;
    x = a[7:0];
    if (b) return {24'h0, refm[x]};
    return {refm[x + 8'd3], refm[x + 8'd2], refm[x + 8'd1], refm[x]};
  endfunction

  task automatic drive(
    input logic sv, input w_t sa, input w_t sd, input logic sb,
    input logic lv, input w_t la, input logic lb
  );
    @(negedge clk);
    in_sv = sv; in_sa = sa; in_sd = sd; in_sb = sb;
    in_lv = lv; in_la = la; in_lb = lb;
    bus.st_valid = sv;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.st_byte  = sb;
    bus.ld_valid = lv;
    bus.ld_addr  = la;
    bus.ld_byte  = lb;
    #1;
  endtask

  // Compare this cycle's outputs with the model, then apply the edge.
  task automatic check_model();
    int   yi;
    bit   full, port;
    logic e_stall, e_we, e_tp;
    w_t   e_ld, e_a, e_wd;
    ent_t h;
    full = (sbq.size() == DEPTH);
    yi = -1;
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (yi < 0 && ovl(sbq[i].addr, sbq[i].b, in_la, in_lb)) yi = i;
    port    = in_lv && (yi < 0) && !full;
    e_stall = 1'b0;
    e_ld    = '0;
    e_we    = (sbq.size() > 0) && !port;
    e_a     = '0;
    e_wd    = '0;
    e_tp    = 1'b0;
    if (in_lv) begin
      if (in_sv) begin
        e_stall = 1'b1;
      end else if (yi >= 0) begin
        if (sbq[yi].addr == in_la && sbq[yi].b == in_lb)
          e_ld = in_lb ? {24'h0, sbq[yi].data[7:0]} : sbq[yi].data;
        else
          e_stall = 1'b1;
      end else if (full) begin
        e_stall = 1'b1;
      end else begin
        e_ld = ref_rd(in_la, in_lb);
      end
    end
    if (port) begin
      e_a  = in_la;
      e_tp = in_lb;
    end else if (e_we) begin
      e_a  = sbq[0].addr;
      e_wd = sbq[0].data;
      e_tp = sbq[0].b;
    end
    chk("m.st_ready", w_t'(bus.st_ready), w_t'(!full));
    chk("m.ld_stall", w_t'(bus.ld_stall), w_t'(e_stall));
    if (!in_lv || !e_stall) chk("m.ld_data", bus.ld_data, e_ld);
    chk("m.mem_WE", w_t'(bus.mem_WE), w_t'(e_we));
    chk("m.mem_A", bus.mem_A, e_a);
    chk("m.mem_WD", bus.mem_WD, e_wd);
    chk("m.mem_ADTP", w_t'(bus.mem_ADTP), w_t'(e_tp));
    if (e_we) begin
      h = sbq.pop_front();
      if (h.b) begin
        refm[h.addr[7:0]] = h.data[7:0];
      end else begin
        for (int k = 0; k < 4; k++)
          refm[h.addr[7:0] + 8'(k)] = h.data[8*k +: 8];
      end
    end
    if (in_sv && !full) sbq.push_back('{in_sa, in_sd, in_sb});
  endtask

  task automatic step(
    input logic sv, input w_t sa, input w_t sd, input logic sb,
    input logic lv, input w_t la, input logic lb
  );
    drive(sv, sa, sd, sb, lv, la, lb);
    check_model();
  endtask

  typedef struct {
    logic sv; w_t sa; w_t sd; logic sb;
    logic lv; w_t la; logic lb;
    logic rdy; logic stl; w_t ld;
    logic we; w_t a; w_t wd; logic tp;
  } vec_t;

  function automatic vec_t mkv(
    logic sv, w_t sa, w_t sd, logic sb,
    logic lv, w_t la, logic lb,
    logic rdy, logic stl, w_t ld,
    logic we, w_t a, w_t wd, logic tp
  );
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.sb = sb;
    v.lv = lv; v.la = la; v.lb = lb;
    v.rdy = rdy; v.stl = stl; v.ld = ld;
    v.we = we; v.a = a; v.wd = wd; v.tp = tp;
    return v;
  endfunction

  function automatic w_t rand_addr();
    if ($urandom_range(0, 4) == 0)
      return 32'hFFFF_FFFC + w_t'($urandom_range(0, 7));
    return 32'h0001_0000 + w_t'($urandom_range(0, 23));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [17];
    int   base, k, r, bad;
    bit   pushed;
    logic sv, lv;

    vt[0]  = mkv(1'b1, 32'h10000, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    vt[1]  = mkv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 32'h0, 1'b1, 32'h10000, 32'hDEADBEEF, 1'b0);
    vt[2]  = mkv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    vt[3]  = mkv(1'b1, 32'h10004, 32'h11223344, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    vt[4]  = mkv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10004, 1'b0,
                 1'b1, 1'b0, 32'h11223344,
                 1'b1, 32'h10004, 32'h11223344, 1'b0);
    vt[5]  = mkv(1'b1, 32'h10008, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    vt[6]  = mkv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10009, 1'b1,
                 1'b1, 1'b1, 32'h0, 1'b1, 32'h10008, 32'hAABBCCDD, 1'b0);
    vt[7]  = mkv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10009, 1'b1,
                 1'b1, 1'b0, 32'hCC, 1'b0, 32'h10009, 32'h0, 1'b1);
    vt[8]  = mkv(1'b1, 32'h10010, 32'h7F, 1'b1, 1'b1, 32'h10100, 1'b0,
                 1'b1, 1'b1, 32'h0, 1'b0, 32'h10100, 32'h0, 1'b0);
    vt[9]  = mkv(1'b1, 32'h10010, 32'h01020304, 1'b0,
                 1'b1, 32'h10100, 1'b0,
                 1'b1, 1'b1, 32'h0, 1'b0, 32'h10100, 32'h0, 1'b0);
    vt[10] = mkv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10010, 1'b1,
                 1'b1, 1'b1, 32'h0, 1'b1, 32'h10010, 32'h7F, 1'b1);
    vt[11] = mkv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10010, 1'b1,
                 1'b1, 1'b1, 32'h0, 1'b1, 32'h10010, 32'h01020304, 1'b0);
    vt[12] = mkv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10010, 1'b1,
                 1'b1, 1'b0, 32'h04, 1'b0, 32'h10010, 32'h0, 1'b1);
    vt[13] = mkv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10010, 1'b0,
                 1'b1, 1'b0, 32'h01020304, 1'b0, 32'h10010, 32'h0, 1'b0);
    vt[14] = mkv(1'b1, 32'hFFFFFFFE, 32'h55667788, 1'b0,
                 1'b1, 32'h10100, 1'b0,
                 1'b1, 1'b1, 32'h0, 1'b0, 32'h10100, 32'h0, 1'b0);
    vt[15] = mkv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b1,
                 1'b1, 1'b1, 32'h0,
                 1'b1, 32'hFFFFFFFE, 32'h55667788, 1'b0);
    vt[16] = mkv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b1,
                 1'b1, 1'b0, 32'h55, 1'b0, 32'h1, 32'h0, 1'b1);

    // Reset with both requests active: every output must read zero.
    bus.st_valid = 1'b1;
    bus.st_addr  = 32'h10000;
    bus.st_data  = 32'h12345678;
    bus.st_byte  = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h10040;
    bus.ld_byte  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.st_ready", w_t'(bus.st_ready), 32'h0);
    chk("rst.ld_stall", w_t'(bus.ld_stall), 32'h0);
    chk("rst.ld_data", bus.ld_data, 32'h0);
    chk("rst.mem_WE", w_t'(bus.mem_WE), 32'h0);
    chk("rst.mem_A", bus.mem_A, 32'h0);
    chk("rst.mem_WD", bus.mem_WD, 32'h0);
    chk("rst.mem_ADTP", w_t'(bus.mem_ADTP), 32'h0);
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].sv, vt[i].sa, vt[i].sd, vt[i].sb,
            vt[i].lv, vt[i].la, vt[i].lb);
      chk($sformatf("v%0d.st_ready", i), w_t'(bus.st_ready), w_t'(vt[i].rdy));
      chk($sformatf("v%0d.ld_stall", i), w_t'(bus.ld_stall), w_t'(vt[i].stl));
      if (!vt[i].lv || !vt[i].stl)
        chk($sformatf("v%0d.ld_data", i), bus.ld_data, vt[i].ld);
      chk($sformatf("v%0d.mem_WE", i), w_t'(bus.mem_WE), w_t'(vt[i].we));
      chk($sformatf("v%0d.mem_A", i), bus.mem_A, vt[i].a);
      chk($sformatf("v%0d.mem_WD", i), bus.mem_WD, vt[i].wd);
      chk($sformatf("v%0d.mem_ADTP", i), w_t'(bus.mem_ADTP), w_t'(vt[i].tp));
      check_model();
    end

    // Five stores against a continuous non-overlapping load.
    @(posedge clk);
    #1;
    base = wr_addr.size();
    k = 0;
    for (int c = 0; c < 10; c++) begin
      drive(k < 5, 32'h10020 + w_t'(4 * k), 32'hC0DE0000 + w_t'(k), 1'b0,
            1'b1, 32'h10200, 1'b0);
      if (c == 4) begin
        chk("full.st_ready", w_t'(bus.st_ready), 32'h0);
        chk("full.ld_stall", w_t'(bus.ld_stall), 32'h1);
        chk("full.mem_WE", w_t'(bus.mem_WE), 32'h1);
        chk("full.mem_A", bus.mem_A, 32'h10020);
      end
      pushed = in_sv && (sbq.size() < DEPTH);
      check_model();
      if (pushed) k++;
    end
    for (int c = 0; c < 10 && sbq.size() > 0; c++)
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("seq5.pushes", w_t'(k), 32'd5);
    chk("seq5.writes", w_t'(wr_addr.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < wr_addr.size()) begin
        chk($sformatf("seq5.addr%0d", i), wr_addr[base + i],
            32'h10020 + w_t'(4 * i));
        chk($sformatf("seq5.data%0d", i), wr_data[base + i],
            32'hC0DE0000 + w_t'(i));
      end
    end

    // Three stores held in the buffer, then reset mid-drain.
    for (int c = 0; c < 3; c++)
      step(1'b1, 32'h10040 + w_t'(4 * c), 32'hBAD00000 + w_t'(c), 1'b0,
           1'b1, 32'h10200, 1'b0);
    @(posedge clk);
    #1;
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    in_sv = 1'b0;
    in_lv = 1'b0;
    #1;
    chk("prerst.mem_WE", w_t'(bus.mem_WE), 32'h1);
    base = wr_addr.size();
    rst_n = 1'b0;
    #1;
    chk("midrst.mem_WE", w_t'(bus.mem_WE), 32'h0);
    chk("midrst.st_ready", w_t'(bus.st_ready), 32'h0);
    chk("midrst.mem_A", bus.mem_A, 32'h0);
    chk("midrst.mem_WD", bus.mem_WD, 32'h0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++)
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst.discard", w_t'(wr_addr.size() - base), 32'd0);

    // Randomized traffic, including the illegal store+load mix.
    for (int c = 0; c < 400; c++) begin
      r  = $urandom_range(0, 99);
      sv = (r < 30) || (r >= 60 && r < 85);
      lv = (r >= 30 && r < 85);
      step(sv, rand_addr(), $urandom(), 1'($urandom_range(0, 1)),
           lv, rand_addr(), 1'($urandom_range(0, 1)));
    end
    for (int c = 0; c < 12 && sbq.size() > 0; c++)
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("drain.empty", w_t'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (dmem[i] !== refm[i]) bad++;
    chk("mem.image", w_t'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
